uart_fifo_core: RTL and testbench

- Next-generation parametrised UART for the MIPS system bus. It replaces the three-clock receiver/sender pair with a single-clock design.
- Internal 16x oversampling baud-tick generator.
- Configurable data width; RX and TX FIFOs of parametrised depth.
- Framing-error and overrun detection.
- The CPU peripheral decoder drives tx_wr/rx_rd and polls the status outputs.

---
 rtl/uart_fifo_core.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_uart_fifo_core.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_core.sv
// Single-clock UART core: 16x oversampled RX/TX state machines, each backed by a show-ahead FIFO.
// Defining UART_PARITY_EN adds a parity bit (parity_odd input, rx_parity_err output).

module UartFifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rstN,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_head,
   output logic             o_full,
   output logic             o_empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wrPtr;
   logic [AW:0]      r_rdPtr;
   logic [WIDTH-1:0] r_head;
   logic             r_full;
   logic             r_empty;
   logic             w_pop;
   logic             w_pushOk;
   logic [AW:0]      w_wrNext;
   logic [AW:0]      w_rdNext;

   // A pop frees its slot before a same-cycle push, so a full FIFO can still accept that push
   assign w_pop    = i_pop && !r_empty;
   assign w_pushOk = i_push && (!r_full || w_pop);
   assign w_wrNext = r_wrPtr + {{AW{1'b0}}, w_pushOk};
   assign w_rdNext = r_rdPtr + {{AW{1'b0}}, w_pop};
   assign o_head   = r_head;
   assign o_full   = r_full;
   assign o_empty  = r_empty;

   always_ff @(posedge i_clk) begin
      if (w_pushOk) begin
         r_mem[r_wrPtr[AW-1:0]] <= i_data;
      end
   end

   always_ff @(posedge i_clk or negedge i_rstN) begin
      if (!i_rstN) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_head  <= '0;
         r_full  <= 1'b0;
         r_empty <= 1'b1;
      end else begin
         r_wrPtr <= w_wrNext;
         r_rdPtr <= w_rdNext;
         r_empty <= (w_wrNext == w_rdNext);
         r_full  <= (w_wrNext[AW] != w_rdNext[AW]) && (w_wrNext[AW-1:0] == w_rdNext[AW-1:0]);
         // The head register tracks the entry at the next read pointer, forwarding a push that lands there
         if (w_pushOk && (w_rdNext == r_wrPtr)) begin
            r_head <= i_data;
         end else if (w_pop) begin
            r_head <= r_mem[w_rdNext[AW-1:0]];
         end
      end
   end
endmodule

module uart_fifo_core #(
   parameter int CLK_DIV    = 27,
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       sysclk,
   input  logic       reset_n,
   input  logic       rxd,
   output logic       txd,
   input  logic [7:0] tx_data,
   input  logic       tx_wr,
   output logic       tx_full,
   output logic       tx_busy,
   output logic [7:0] rx_data,
   input  logic       rx_rd,
   output logic       rx_empty,
   output logic       rx_frame_err,
   output logic       rx_overrun
`ifdef UART_PARITY_EN
   ,
   input  logic       parity_odd,
   output logic       rx_parity_err
`endif
);
   localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} UartState;
`ifdef UART_PARITY_EN
   localparam UartState AFTER_DATA = S_PARITY;
`else
   localparam UartState AFTER_DATA = S_STOP;
`endif

   logic [TW-1:0]        r_tickCnt;
   logic                 w_tick;
   logic [1:0]           r_rxSync;
   logic                 w_rxd;
   UartState             r_rxState, w_rxNext, r_txState, w_txNext;
   logic [3:0]           r_rxTick, r_txTick;
   logic [2:0]           r_rxBit, r_txBit;
   logic [DATA_BITS-1:0] r_rxShift, r_txShift;
   logic                 w_rxSample, w_stopSample, w_rxPushReq, w_rxParBad;
   logic                 w_rxFull, w_rxEmpty, w_rxPopEff;
   logic                 w_txBitEnd, w_txPop, w_txEmpty;
   logic [DATA_BITS-1:0] w_rxHead, w_txHead;
   logic                 r_frameErr, r_overrun, r_txBusy;
`ifdef UART_PARITY_EN
   logic                 r_rxParBad, r_parErr, r_txPar;
   assign w_rxParBad    = r_rxParBad;
   assign rx_parity_err = r_parErr;
`else
   assign w_rxParBad = 1'b0;
`endif

   assign w_tick       = (r_tickCnt == TW'(CLK_DIV - 1));
   assign w_rxd        = r_rxSync[1];
   assign rx_data      = 8'(w_rxHead);
   assign rx_empty     = w_rxEmpty;
   assign rx_frame_err = r_frameErr;
   assign rx_overrun   = r_overrun;
   assign tx_busy      = r_txBusy;

   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
         r_tickCnt <= '0;
         r_rxSync  <= 2'b11;
      end else begin
         r_tickCnt <= w_tick ? '0 : r_tickCnt + 1'b1;
         r_rxSync  <= {r_rxSync[0], rxd};
      end
   end

   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
         r_rxState <= S_IDLE;
         r_txState <= S_IDLE;
      end else begin
         r_rxState <= w_rxNext;
         r_txState <= w_txNext;
      end
   end

   // The start bit is sampled mid-bit (8 ticks in); every later sample is a full bit period apart
   assign w_rxSample = w_tick && (r_rxTick == ((r_rxState == S_START) ? 4'd7 : 4'd15));

   always_comb begin
      w_rxNext = r_rxState;
      case (r_rxState)
         S_IDLE:   if (w_tick && !w_rxd) w_rxNext = S_START;
         S_START:  if (w_rxSample) w_rxNext = w_rxd ? S_IDLE : S_DATA;
         S_DATA:   if (w_rxSample && (r_rxBit == 3'(DATA_BITS - 1))) w_rxNext = AFTER_DATA;
         S_PARITY: if (w_rxSample) w_rxNext = S_STOP;
         S_STOP:   if (w_rxSample) w_rxNext = S_IDLE;
         default:  w_rxNext = S_IDLE;
      endcase
   end

   always_comb begin
      w_stopSample = (r_rxState == S_STOP) && w_rxSample;
      w_rxPushReq  = w_stopSample && w_rxd && !w_rxParBad;
      w_rxPopEff   = rx_rd && !w_rxEmpty;
   end

   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
         r_rxTick   <= '0;
         r_rxBit    <= '0;
         r_rxShift  <= '0;
         r_frameErr <= 1'b0;
         r_overrun  <= 1'b0;
`ifdef UART_PARITY_EN
         r_rxParBad <= 1'b0;
         r_parErr   <= 1'b0;
`endif
      end else begin
         if (r_rxState == S_IDLE || w_rxSample) begin
            r_rxTick <= '0;
         end else if (w_tick) begin
            r_rxTick <= r_rxTick + 4'd1;
         end
         if (r_rxState != S_DATA) begin
            r_rxBit <= '0;
         end else if (w_rxSample) begin
            r_rxBit   <= r_rxBit + 3'd1;
            r_rxShift <= {w_rxd, r_rxShift[DATA_BITS-1:1]};
         end
         r_frameErr <= w_stopSample && !w_rxd;
         r_overrun  <= w_rxPushReq && w_rxFull && !w_rxPopEff;
`ifdef UART_PARITY_EN
         if (r_rxState == S_PARITY && w_rxSample) begin
            r_rxParBad <= w_rxd != ((^r_rxShift) ^ parity_odd);
         end
         r_parErr <= w_stopSample && r_rxParBad;
`endif
      end
   end

   assign w_txBitEnd = w_tick && (r_txTick == 4'd15);

   always_comb begin
      w_txNext = r_txState;
      case (r_txState)
         S_IDLE:   if (w_tick && !w_txEmpty) w_txNext = S_START;
         S_START:  if (w_txBitEnd) w_txNext = S_DATA;
         S_DATA:   if (w_txBitEnd && (r_txBit == 3'(DATA_BITS - 1))) w_txNext = AFTER_DATA;
         S_PARITY: if (w_txBitEnd) w_txNext = S_STOP;
         S_STOP:   if (w_txBitEnd) w_txNext = w_txEmpty ? S_IDLE : S_START;
         default:  w_txNext = S_IDLE;
      endcase
   end

   always_comb begin
      w_txPop = (w_txNext == S_START) && (r_txState != S_START);
      case (r_txState)
         S_START:  txd = 1'b0;
         S_DATA:   txd = r_txShift[0];
`ifdef UART_PARITY_EN
         S_PARITY: txd = r_txPar;
`endif
         default:  txd = 1'b1;
      endcase
   end

   // Popping only ever happens on the way into START, so busy needs no FIFO next-state lookahead
   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
         r_txTick  <= '0;
         r_txBit   <= '0;
         r_txShift <= '0;
         r_txBusy  <= 1'b0;
`ifdef UART_PARITY_EN
         r_txPar   <= 1'b0;
`endif
      end else begin
         if (r_txState == S_IDLE) begin
            r_txTick <= '0;
         end else if (w_tick) begin
            r_txTick <= r_txTick + 4'd1;
         end
         if (r_txState != S_DATA) begin
            r_txBit <= '0;
         end else if (w_txBitEnd) begin
            r_txBit <= r_txBit + 3'd1;
         end
         if (w_txPop) begin
            r_txShift <= w_txHead;
`ifdef UART_PARITY_EN
            r_txPar   <= (^w_txHead) ^ parity_odd;
`endif
         end else if (r_txState == S_DATA && w_txBitEnd) begin
            r_txShift <= r_txShift >> 1;
         end
         r_txBusy <= (w_txNext != S_IDLE) || tx_wr || !w_txEmpty;
      end
   end

   UartFifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rxFifo (
      .i_clk   (sysclk),
      .i_rstN  (reset_n),
      .i_push  (w_rxPushReq),
      .i_data  (r_rxShift),
      .i_pop   (rx_rd),
      .o_head  (w_rxHead),
      .o_full  (w_rxFull),
      .o_empty (w_rxEmpty)
   );

   UartFifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_txFifo (
      .i_clk   (sysclk),
      .i_rstN  (reset_n),
      .i_push  (tx_wr),
      .i_data  (tx_data[DATA_BITS-1:0]),
      .i_pop   (w_txPop),
      .o_head  (w_txHead),
      .o_full  (tx_full),
      .o_empty (w_txEmpty)
   );
endmodule

// File: tb/tb_uart_fifo_core.sv
// Directed bench for uart_fifo_core at CLK_DIV=4 (64 clocks per bit), FIFO_DEPTH=4.
module tb_uart_fifo_core;
   localparam int CLK_DIV = 4;
   localparam int BIT     = 16 * CLK_DIV;
`ifdef UART_PARITY_EN
   localparam int FRAME = 11;
`else
   localparam int FRAME = 10;
`endif

   typedef struct packed {
      logic [7:0] data;
      logic       stopBit;
      logic       expPush;
      logic       expFrameErr;
   } RxVec;

   logic       sysclk = 1'b0;
   logic       reset_n = 1'b0;
   logic       rxd = 1'b1;
   logic       txd;
   logic [7:0] tx_data = 8'h00;
   logic       tx_wr = 1'b0;
   logic       tx_full, tx_busy;
   logic [7:0] rx_data;
   logic       rx_rd = 1'b0;
   logic       rx_empty, rx_frame_err, rx_overrun;
   logic       parityOdd = 1'b0;
   logic       rxParErr;

   int checks = 0;
   int failures = 0;
   int tbCnt;
   int frameErrSeen = 0;
   int overrunSeen = 0;
   int parErrSeen = 0;
   int feBase, ovBase, peBase;

   RxVec                 rxVecs [4];
   logic [5*FRAME-1:0]   early, late;
   logic                 busyLast;
   logic [7:0]           txBytes [6];
   logic                 fullAfter [6];

   uart_fifo_core #(.CLK_DIV(CLK_DIV), .DATA_BITS(8), .FIFO_DEPTH(4)) dut (
      .sysclk        (sysclk),
      .reset_n       (reset_n),
      .rxd           (rxd),
      .txd           (txd),
      .tx_data       (tx_data),
      .tx_wr         (tx_wr),
      .tx_full       (tx_full),
      .tx_busy       (tx_busy),
      .rx_data       (rx_data),
      .rx_rd         (rx_rd),
      .rx_empty      (rx_empty),
      .rx_frame_err  (rx_frame_err),
      .rx_overrun    (rx_overrun)
`ifdef UART_PARITY_EN
      ,
      .parity_odd    (parityOdd),
      .rx_parity_err (rxParErr)
`endif
   );
`ifndef UART_PARITY_EN
   assign rxParErr = 1'b0;
`endif

   always #5 sysclk = ~sysclk;

   // Free-running model of the baud-tick phase so stimulus can be launched on a known tick edge
   always @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) tbCnt <= 0;
      else          tbCnt <= (tbCnt == CLK_DIV - 1) ? 0 : tbCnt + 1;
   end

   always @(negedge sysclk) begin
      if (rx_frame_err) frameErrSeen <= frameErrSeen + 1;
      if (rx_overrun)   overrunSeen  <= overrunSeen + 1;
      if (rxParErr)     parErrSeen   <= parErrSeen + 1;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   function automatic logic [FRAME-1:0] buildFrame(input logic [7:0] d);
      logic [FRAME-1:0] f;
      f = '1;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[1+i] = d[i];
`ifdef UART_PARITY_EN
      f[9] = (^d) ^ parityOdd;
`endif
      return f;
   endfunction

   // Drives one serial frame on rxd, one bit per BIT clocks, then leaves the line idle
   task automatic applyStimulus(input logic [7:0] d, input logic stopBit);
      logic [FRAME-1:0] f;
      f = buildFrame(d);
      f[FRAME-1] = stopBit;
      for (int b = 0; b < FRAME; b++) begin
         rxd = f[b];
         repeat (BIT) @(negedge sysclk);
      end
      rxd = 1'b1;
   endtask

   task automatic popRx();
      rx_rd = 1'b1;
      @(negedge sysclk);
      rx_rd = 1'b0;
   endtask

   task automatic alignTick();
      @(negedge sysclk);
      for (int g = 0; g < 2 * CLK_DIV && tbCnt != CLK_DIV - 1; g++) @(negedge sysclk);
   endtask

   // Samples txd just after the start and at the last cycle of every bit, c counted from the frame start edge
   task automatic captureFrames(input int nFrames, input int startC,
                                output logic [5*FRAME-1:0] eOut, output logic [5*FRAME-1:0] lOut,
                                output logic busyOut);
      eOut = '0;
      lOut = '0;
      busyOut = 1'b0;
      for (int c = startC; c < nFrames * FRAME * BIT; c++) begin
         if (c % BIT == 1)       eOut[c / BIT] = txd;
         if (c % BIT == BIT - 1) lOut[c / BIT] = txd;
         if (c == nFrames * FRAME * BIT - 1) busyOut = tx_busy;
         @(negedge sysclk);
      end
   endtask

   initial begin
      rxVecs[0] = '{data: 8'hA3, stopBit: 1'b1, expPush: 1'b1, expFrameErr: 1'b0};
      rxVecs[1] = '{data: 8'h81, stopBit: 1'b0, expPush: 1'b0, expFrameErr: 1'b1};
      rxVecs[2] = '{data: 8'h00, stopBit: 1'b1, expPush: 1'b1, expFrameErr: 1'b0};
      rxVecs[3] = '{data: 8'hFF, stopBit: 1'b1, expPush: 1'b1, expFrameErr: 1'b0};
      txBytes[0] = 8'h07; txBytes[1] = 8'h11; txBytes[2] = 8'h22;
      txBytes[3] = 8'h33; txBytes[4] = 8'h44; txBytes[5] = 8'h55;

      repeat (5) @(negedge sysclk);
      checkOutput("reset_txd", {31'd0, txd}, 32'd1);
      checkOutput("reset_tx_full", {31'd0, tx_full}, 32'd0);
      checkOutput("reset_tx_busy", {31'd0, tx_busy}, 32'd0);
      checkOutput("reset_rx_empty", {31'd0, rx_empty}, 32'd1);
      checkOutput("reset_rx_data", {24'd0, rx_data}, 32'd0);
      checkOutput("reset_pulses", {30'd0, rx_frame_err, rx_overrun}, 32'd0);
      reset_n = 1'b1;
      repeat (3) @(negedge sysclk);

      $display("[TB] single TX frame 0x55");
      alignTick();
      tx_data = 8'h55;
      tx_wr = 1'b1;
      @(negedge sysclk);
      tx_wr = 1'b0;
      checkOutput("tx_busy_after_wr", {31'd0, tx_busy}, 32'd1);
      repeat (3) @(negedge sysclk);
      checkOutput("txd_before_start", {31'd0, txd}, 32'd1);
      @(negedge sysclk);
      captureFrames(1, 0, early, late, busyLast);
      checkOutput("tx55_bits_early", 32'(early[FRAME-1:0]), 32'(buildFrame(8'h55)));
      checkOutput("tx55_bits_late", 32'(late[FRAME-1:0]), 32'(buildFrame(8'h55)));
      checkOutput("tx55_busy_in_stop", {31'd0, busyLast}, 32'd1);
      checkOutput("tx55_busy_after", {31'd0, tx_busy}, 32'd0);
      checkOutput("tx55_txd_idle", {31'd0, txd}, 32'd1);

      $display("[TB] RX vector table");
      for (int v = 0; v < 4; v++) begin
         feBase = frameErrSeen;
         ovBase = overrunSeen;
         applyStimulus(rxVecs[v].data, rxVecs[v].stopBit);
         repeat (40) @(negedge sysclk);
         checkOutput($sformatf("rx%0d_empty", v), {31'd0, rx_empty}, {31'd0, !rxVecs[v].expPush});
         checkOutput($sformatf("rx%0d_frame_err", v), frameErrSeen - feBase, {31'd0, rxVecs[v].expFrameErr});
         checkOutput($sformatf("rx%0d_overrun", v), overrunSeen - ovBase, 32'd0);
         if (rxVecs[v].expPush) begin
            checkOutput($sformatf("rx%0d_data", v), {24'd0, rx_data}, {24'd0, rxVecs[v].data});
            popRx();
            checkOutput($sformatf("rx%0d_empty_after_rd", v), {31'd0, rx_empty}, 32'd1);
         end
      end

      $display("[TB] RX glitch then 0x3C");
      feBase = frameErrSeen;
      rxd = 1'b0;
      repeat (20) @(negedge sysclk);
      rxd = 1'b1;
      repeat (100) @(negedge sysclk);
      checkOutput("glitch_empty", {31'd0, rx_empty}, 32'd1);
      checkOutput("glitch_frame_err", frameErrSeen - feBase, 32'd0);
      applyStimulus(8'h3C, 1'b1);
      repeat (40) @(negedge sysclk);
      checkOutput("after_glitch_empty", {31'd0, rx_empty}, 32'd0);
      checkOutput("after_glitch_data", {24'd0, rx_data}, 32'h3C);
      popRx();

      $display("[TB] RX overrun with five frames");
      feBase = frameErrSeen;
      ovBase = overrunSeen;
      peBase = parErrSeen;
      for (int k = 1; k <= 4; k++) applyStimulus(8'(k), 1'b1);
      repeat (20) @(negedge sysclk);
      checkOutput("ovr_before_5th", overrunSeen - ovBase, 32'd0);
      applyStimulus(8'h05, 1'b1);
      repeat (40) @(negedge sysclk);
      checkOutput("ovr_pulses", overrunSeen - ovBase, 32'd1);
      checkOutput("ovr_frame_err", frameErrSeen - feBase, 32'd0);
      checkOutput("ovr_parity_err", parErrSeen - peBase, 32'd0);
      for (int k = 1; k <= 4; k++) begin
         checkOutput($sformatf("ovr_rd%0d_data", k), {24'd0, rx_data}, 32'(k));
         popRx();
      end
      checkOutput("ovr_empty_after_reads", {31'd0, rx_empty}, 32'd1);

      $display("[TB] six back-to-back TX writes");
      alignTick();
      for (int k = 0; k < 6; k++) begin
         tx_data = txBytes[k];
         tx_wr = 1'b1;
         @(negedge sysclk);
         fullAfter[k] = tx_full;
      end
      tx_wr = 1'b0;
      checkOutput("tx_full_after_3rd", {31'd0, fullAfter[2]}, 32'd0);
      checkOutput("tx_full_after_4th", {31'd0, fullAfter[3]}, 32'd1);
      checkOutput("tx_full_after_6th", {31'd0, fullAfter[5]}, 32'd1);
      captureFrames(5, 1, early, late, busyLast);
      for (int k = 0; k < 5; k++) begin
         checkOutput($sformatf("burst%0d_early", k), 32'(early[k*FRAME +: FRAME]), 32'(buildFrame(txBytes[k])));
         checkOutput($sformatf("burst%0d_late", k), 32'(late[k*FRAME +: FRAME]), 32'(buildFrame(txBytes[k])));
      end
      checkOutput("burst_busy_last_stop", {31'd0, busyLast}, 32'd1);
      checkOutput("burst_busy_after", {31'd0, tx_busy}, 32'd0);

      $display("[TB] reset during a TX frame");
      alignTick();
      tx_data = 8'hF0;
      tx_wr = 1'b1;
      @(negedge sysclk);
      tx_wr = 1'b0;
      repeat (200) @(negedge sysclk);
      reset_n = 1'b0;
      #1;
      checkOutput("midreset_txd", {31'd0, txd}, 32'd1);
      checkOutput("midreset_busy", {31'd0, tx_busy}, 32'd0);
      @(negedge sysclk);
      reset_n = 1'b1;
      repeat (300) @(negedge sysclk);
      checkOutput("postreset_txd", {31'd0, txd}, 32'd1);
      checkOutput("postreset_busy", {31'd0, tx_busy}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
